// File: rtl/lut_sweep_pkg.sv
// Shared types and width helpers for the LUT function sweeper.
package lut_sweep_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  function automatic int depth_of(input int w);
    return 1 << w;
  endfunction

  function automatic int cnt_w_of(input int w);
    return w + 1;
  endfunction

  localparam int LUT_W = 4;
  localparam int DEPTH = depth_of(LUT_W);
  localparam int CNT_W = cnt_w_of(LUT_W);

endpackage

// File: rtl/lut_shift_table.sv
// Serially loaded truth table: shifts right, new bit enters the top entry.
module lut_shift_table
  import lut_sweep_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         din,
  input  logic [W-1:0] addr,
  output logic         dout
);

  localparam int D = depth_of(W);

  logic [D-1:0] tab;

  // After D shifts the first bit loaded has reached entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tab <= '0;
    end else if (shift_en) begin
      tab <= {din, tab[D-1:1]};
    end
  end

  assign dout = tab[addr];

endmodule

// File: rtl/lut_func_sweeper.sv
// Programmable Boolean function unit: serial table load, single queries, full sweeps.
// Define LUT_SWEEP_CNT_EN to build the minterm (ones) counter; otherwise ones_cnt is 0.
module lut_func_sweeper
  import lut_sweep_pkg::*;
#(
  parameter int W = LUT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic         load_bit,
  input  logic         start,
  input  logic [W-1:0] n_in,
  output logic         f_out,
  output logic         f_valid,
  output logic [W-1:0] sweep_n,
  output logic         busy,
  output logic         done,
  output logic [W:0]   ones_cnt
);

  localparam int D = depth_of(W);
  localparam logic [W-1:0] LAST = W'(D - 1);

  state_t       state;
  logic [W-1:0] idx;
  logic [W-1:0] rd_addr;
  logic         tab_bit;
  logic         shift_en;
  logic         go;

  assign shift_en = load_en && (state == IDLE);
  // A start coinciding with a load is dropped, not queued.
  assign go       = (state == IDLE) && start && !load_en;
  assign rd_addr  = (state == SWEEP) ? idx : n_in;

  lut_shift_table #(.W(W)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (load_bit),
    .addr     (rd_addr),
    .dout     (tab_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      f_out   <= 1'b0;
      f_valid <= 1'b0;
      sweep_n <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          f_out   <= tab_bit;
          f_valid <= 1'b0;
          if (go) begin
            state <= SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          f_out   <= tab_bit;
          sweep_n <= idx;
          f_valid <= 1'b1;
          // Terminal compare keeps idx from wrapping past the last code.
          if (idx == LAST) begin
            state <= DONE;
          end else begin
            idx <= idx + W'(1);
          end
        end
        DONE: begin
          f_valid <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LUT_SWEEP_CNT_EN
  logic [W:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (go) begin
      cnt <= '0;
    end else if (state == SWEEP) begin
      cnt <= cnt + {{W{1'b0}}, tab_bit};
    end
  end

  assign ones_cnt = cnt;
`else
  assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_lut_func_sweeper.sv
// Scoreboard bench for lut_func_sweeper at W=4 and W=1 with a load-history reference model.
module tb_lut_func_sweeper;
  import lut_sweep_pkg::*;

  localparam int W  = LUT_W;
  localparam int D1 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         load_en, load_bit, start;
  logic [W-1:0] n_in;
  logic         f_out, f_valid, busy, done;
  logic [W-1:0] sweep_n;
  logic [CNT_W-1:0] ones_cnt;

  logic       a_load_en, a_load_bit, a_start;
  logic [0:0] a_n_in;
  logic       a_f_out, a_f_valid, a_busy, a_done;
  logic [0:0] a_sweep_n;
  logic [1:0] a_ones_cnt;

  lut_func_sweeper #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_bit(load_bit), .start(start),
    .n_in(n_in), .f_out(f_out), .f_valid(f_valid), .sweep_n(sweep_n), .busy(busy),
    .done(done), .ones_cnt(ones_cnt)
  );

  lut_func_sweeper #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_en(a_load_en), .load_bit(a_load_bit), .start(a_start),
    .n_in(a_n_in), .f_out(a_f_out), .f_valid(a_f_valid), .sweep_n(a_sweep_n), .busy(a_busy),
    .done(a_done), .ones_cnt(a_ones_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  int q4[$];
  int ones_q4[$];
  int q1[$];
  int ones_q1[$];
  int done_cnt4 = 0;

  // Reference model: the table is the last DEPTH bits loaded since reset, oldest at entry 0.
  bit hist4[$];
  bit hist1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_entry(input bit h[$], input int depth, input int i);
    int k;
    k = h.size() - depth + i;
    return (k >= 0) ? h[k] : 1'b0;
  endfunction

  function automatic int m_ones(input bit h[$], input int depth);
    int s;
    s = 0;
    for (int i = 0; i < depth; i++) s += m_entry(h, depth, i);
`ifdef LUT_SWEEP_CNT_EN
    return s;
`else
    return 0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input bit b);
    load_en = 1'b1; load_bit = b;
    tick;
    load_en = 1'b0;
    hist4.push_back(b);
  endtask

  task automatic load_func(input logic [DEPTH-1:0] v);
    for (int i = 0; i < DEPTH; i++) load4(v[i]);
  endtask

  task automatic query4(input int n);
    n_in = W'(n);
    tick;
    chk($sformatf("query_%0d", n), f_out, m_entry(hist4, DEPTH, n));
  endtask

  task automatic sweep4(input bit poke);
    bit seen;
    for (int i = 0; i < DEPTH; i++) q4.push_back(i * 2 + m_entry(hist4, DEPTH, i));
    ones_q4.push_back(m_ones(hist4, DEPTH));
    start = 1'b1;
    tick;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (poke && k == 5) begin start = 1'b1; load_en = 1'b1; load_bit = 1'b1; end
      if (poke && k == 6) begin start = 1'b0; load_en = 1'b0; end
      tick;
      if (done) begin
        seen = 1'b1;
        chk("done_latency", k, DEPTH + 1);
        chk("busy_low_at_done", busy, 0);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic sweep1;
    bit seen;
    for (int i = 0; i < D1; i++) q1.push_back(i * 2 + m_entry(hist1, D1, i));
    ones_q1.push_back(m_ones(hist1, D1));
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick;
      if (a_done) begin
        seen = 1'b1;
        chk("w1_done_latency", k, D1 + 1);
      end
    end
    if (!seen) chk("w1_done_timeout", 0, 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_f_out"}, f_out, 0);
    chk({tag, "_f_valid"}, f_valid, 0);
    chk({tag, "_sweep_n"}, sweep_n, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ones_cnt"}, ones_cnt, 0);
  endtask

  // Monitors consume expectations whenever the DUTs present sweep data or done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (f_valid) begin
        if (q4.size() == 0) chk("w4_valid_unexpected", 1, 0);
        else chk("w4_sweep_n_f", {sweep_n, f_out}, q4.pop_front());
      end
      if (done) begin
        done_cnt4++;
        if (ones_q4.size() == 0) chk("w4_done_unexpected", 1, 0);
        else begin
          chk("w4_ones_cnt", ones_cnt, ones_q4.pop_front());
          chk("w4_valid_count", q4.size(), 0);
        end
      end
      if (a_f_valid) begin
        if (q1.size() == 0) chk("w1_valid_unexpected", 1, 0);
        else chk("w1_sweep_n_f", {a_sweep_n, a_f_out}, q1.pop_front());
      end
      if (a_done) begin
        if (ones_q1.size() == 0) chk("w1_done_unexpected", 1, 0);
        else begin
          chk("w1_ones_cnt", a_ones_cnt, ones_q1.pop_front());
          chk("w1_valid_count", q1.size(), 0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    bit found;
    logic [DEPTH-1:0] v;
    load_en = 0; load_bit = 0; start = 0; n_in = '0;
    a_load_en = 0; a_load_bit = 0; a_start = 0; a_n_in = '0;
    rst_n = 1'b0;
    #3;
    chk_zero_outputs("reset");
    #9 rst_n = 1'b1;
    tick;
    query4(5);

    load_func(16'h28AC);
    chk("prime_q7_const", m_entry(hist4, DEPTH, 7), 1);
    query4(7);
    query4(9);
    query4(13);
    sweep4(1'b0);
    tick;

    sweep4(1'b1);
    tick;
    query4(13);
    query4(2);
    query4(4);

    start = 1'b1; load_en = 1'b1; load_bit = 1'b1;
    tick;
    start = 1'b0; load_en = 1'b0;
    hist4.push_back(1'b1);
    chk("start_load_no_busy", busy, 0);
    tick;
    chk("start_load_no_valid", f_valid, 0);
    query4(15);
    query4(1);
    query4(0);

    load_func(16'hFFFF);
    sweep4(1'b0);
    tick;

    for (int r = 0; r < 4; r++) begin
      v = DEPTH'($urandom);
      load_func(v);
      for (int j = 0; j < 3; j++) query4(int'($urandom_range(DEPTH - 1, 0)));
      sweep4(1'b0);
      tick;
    end

    a_load_en = 1'b1; a_load_bit = 1'b0; tick; hist1.push_back(1'b0);
    a_load_bit = 1'b1; tick; hist1.push_back(1'b1);
    a_load_en = 1'b0;
    a_n_in = 1'b0; tick; chk("w1_query0", a_f_out, m_entry(hist1, D1, 0));
    a_n_in = 1'b1; tick; chk("w1_query1", a_f_out, m_entry(hist1, D1, 1));
    sweep1;
    tick;

    load_func(16'h28AC);
    for (int i = 0; i < DEPTH; i++) q4.push_back(i * 2 + m_entry(hist4, DEPTH, i));
    ones_q4.push_back(m_ones(hist4, DEPTH));
    start = 1'b1; tick; start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick;
      if (f_valid && sweep_n == W'(8)) found = 1'b1;
    end
    chk("abort_reached_step8", found, 1);
    #2 rst_n = 1'b0;
    q4.delete();
    ones_q4.delete();
    hist4.delete();
    hist1.delete();
    #1;
    chk_zero_outputs("abort");
    dc = done_cnt4;
    tick; tick;
    #2 rst_n = 1'b1;
    repeat (20) tick;
    chk("abort_no_done", done_cnt4, dc);
    query4(13);
    sweep4(1'b0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
